// File: rtl/axis_stream_fifo.sv
// AXI-Stream FIFO with first-word-fall-through output, occupancy/packet counters
// and an optional store-and-forward mode that releases words only once a packet is complete.
module axis_stream_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         pkt_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [DATA_WIDTH:0] head;
    logic                full;
    logic                empty;
    logic                release_ok;
    logic                push;
    logic                pop;
    logic                push_last;
    logic                pop_last;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // In packet mode a full buffer also releases words, so packets longer than DEPTH cannot deadlock.
    assign release_ok = (PACKET_MODE == 0) || (pkt_count != '0) || full;

    assign s_tready = !full && !reset;
    assign m_tvalid = !reset && !empty && release_ok;

    assign head    = mem[rd_ptr];
    assign m_tdata = m_tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign m_tlast = m_tvalid && head[DATA_WIDTH];

    assign push      = s_tvalid && s_tready;
    assign pop       = m_tvalid && m_tready;
    assign push_last = push && s_tlast;
    assign pop_last  = pop && m_tlast;

    // Storage is never cleared; reset only makes old entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_tlast, s_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pkt_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({push_last, pop_last})
                2'b10:   pkt_count <= pkt_count + CW'(1);
                2'b01:   pkt_count <= pkt_count - CW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_stream_fifo.sv
// Directed bench for axis_stream_fifo: a cut-through and a packet-mode instance share clock and reset.
module tb_axis_stream_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [DW-1:0] ct_s_tdata, ct_m_tdata, pk_s_tdata, pk_m_tdata;
    logic ct_s_tvalid, ct_s_tlast, ct_s_tready, ct_m_tvalid, ct_m_tlast, ct_m_tready;
    logic pk_s_tvalid, pk_s_tlast, pk_s_tready, pk_m_tvalid, pk_m_tlast, pk_m_tready;
    logic [CW-1:0] ct_count, ct_pkt_count, pk_count, pk_pkt_count;

    int tests = 0;
    int fails = 0;

    axis_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) u_ct (
        .clk(clk), .reset(reset),
        .s_tdata(ct_s_tdata), .s_tvalid(ct_s_tvalid), .s_tlast(ct_s_tlast), .s_tready(ct_s_tready),
        .m_tdata(ct_m_tdata), .m_tvalid(ct_m_tvalid), .m_tlast(ct_m_tlast), .m_tready(ct_m_tready),
        .count(ct_count), .pkt_count(ct_pkt_count)
    );

    axis_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) u_pk (
        .clk(clk), .reset(reset),
        .s_tdata(pk_s_tdata), .s_tvalid(pk_s_tvalid), .s_tlast(pk_s_tlast), .s_tready(pk_s_tready),
        .m_tdata(pk_m_tdata), .m_tvalid(pk_m_tvalid), .m_tlast(pk_m_tlast), .m_tready(pk_m_tready),
        .count(pk_count), .pkt_count(pk_pkt_count)
    );

    function automatic logic [7:0] sample(int i);
        return 8'(i * 37 + 11 + (i >> 8));
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ct_s_tvalid = 1'b0; ct_s_tdata = '0; ct_s_tlast = 1'b0; ct_m_tready = 1'b0;
        pk_s_tvalid = 1'b0; pk_s_tdata = '0; pk_s_tlast = 1'b0; pk_m_tready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        ct_s_tvalid = 1'b1; ct_s_tdata = 8'hAA;
        pk_s_tvalid = 1'b1; pk_s_tdata = 8'hAA;
        for (int k = 0; k < 2; k++) begin
            cycle();
            settle();
            tests++;
            if ({ct_s_tready, ct_m_tvalid, ct_count} !== {1'b0, 1'b0, 5'd0}) begin
                fails++;
                $display("FAIL reset_ct_hold: ready/valid/count=%b/%b/%0d, required 0/0/0",
                         ct_s_tready, ct_m_tvalid, ct_count);
            end
            tests++;
            if ({pk_s_tready, pk_m_tvalid, pk_count} !== {1'b0, 1'b0, 5'd0}) begin
                fails++;
                $display("FAIL reset_pk_hold: ready/valid/count=%b/%b/%0d, required 0/0/0",
                         pk_s_tready, pk_m_tvalid, pk_count);
            end
        end
        cycle();
        reset = 1'b0;
        #1;
        tests++;
        if ({ct_s_tready, pk_s_tready} !== 2'b11) begin
            fails++;
            $display("FAIL reset_release_ready: ct/pk ready=%b/%b, required 1/1", ct_s_tready, pk_s_tready);
        end
        cycle();
        ct_s_tvalid = 1'b0; pk_s_tvalid = 1'b0;
        settle();
        tests++;
        if ({ct_m_tvalid, ct_m_tdata, ct_count} !== {1'b1, 8'hAA, 5'd1}) begin
            fails++;
            $display("FAIL reset_first_push: valid/data/count=%b/%0h/%0d, required 1/aa/1",
                     ct_m_tvalid, ct_m_tdata, ct_count);
        end
        tests++;
        if ({pk_m_tvalid, pk_count} !== {1'b0, 5'd1}) begin
            fails++;
            $display("FAIL reset_first_push_pk: valid/count=%b/%0d, required 0/1", pk_m_tvalid, pk_count);
        end
        cycle();
    endtask

    task automatic test_cut_through();
        logic [14:0] exp;
        idle_inputs();
        apply_reset();
        ct_m_tready = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            ct_s_tvalid = 1'b1;
            ct_s_tdata  = sample(i);
            ct_s_tlast  = (i == 10);
            settle();
            if (i == 0) exp = {1'b0, 1'b0, 8'h00, 5'd0};
            else        exp = {1'b1, (i == 11), sample(i - 1), 5'd1};
            tests++;
            if ({ct_m_tvalid, ct_m_tlast, ct_m_tdata, ct_count} !== exp) begin
                fails++;
                $display("FAIL stream_word_%0d: valid/last/data/count=%h, required %h", i,
                         {ct_m_tvalid, ct_m_tlast, ct_m_tdata, ct_count}, exp);
            end
            cycle();
        end
        ct_s_tvalid = 1'b0; ct_s_tlast = 1'b0;
        settle();
        tests++;
        if ({ct_m_tvalid, ct_m_tlast, ct_m_tdata} !== {1'b1, 1'b0, sample(2047)}) begin
            fails++;
            $display("FAIL stream_tail: valid/last/data=%b/%b/%0h, required 1/0/%0h",
                     ct_m_tvalid, ct_m_tlast, ct_m_tdata, sample(2047));
        end
        cycle();
        settle();
        tests++;
        if ({ct_m_tvalid, ct_count} !== {1'b0, 5'd0}) begin
            fails++;
            $display("FAIL stream_empty: valid/count=%b/%0d, required 0/0", ct_m_tvalid, ct_count);
        end
        cycle();
        ct_m_tready = 1'b0;
    endtask

    task automatic test_fill_backpressure();
        logic [7:0] ev;
        idle_inputs();
        apply_reset();
        for (int v = 1; v <= 16; v++) begin
            ct_s_tvalid = 1'b1;
            ct_s_tdata  = 8'(v);
            settle();
            tests++;
            if (ct_s_tready !== 1'b1) begin
                fails++;
                $display("FAIL fill_ready_%0d: s_tready=%b, required 1", v, ct_s_tready);
            end
            cycle();
        end
        ct_s_tdata = 8'h11;
        settle();
        tests++;
        if ({ct_count, ct_s_tready, ct_m_tvalid, ct_m_tdata} !== {5'd16, 1'b0, 1'b1, 8'h01}) begin
            fails++;
            $display("FAIL fill_full: count/ready/valid/data=%0d/%b/%b/%0h, required 16/0/1/01",
                     ct_count, ct_s_tready, ct_m_tvalid, ct_m_tdata);
        end
        cycle();
        settle();
        tests++;
        if (ct_count !== 5'd16) begin
            fails++;
            $display("FAIL fill_held_off: count=%0d, required 16", ct_count);
        end
        ct_m_tready = 1'b1;
        cycle();
        ct_m_tready = 1'b0;
        settle();
        tests++;
        if ({ct_count, ct_s_tready, ct_m_tdata} !== {5'd15, 1'b1, 8'h02}) begin
            fails++;
            $display("FAIL fill_one_pop: count/ready/data=%0d/%b/%0h, required 15/1/02",
                     ct_count, ct_s_tready, ct_m_tdata);
        end
        cycle();
        ct_s_tvalid = 1'b0;
        settle();
        tests++;
        if (ct_count !== 5'd16) begin
            fails++;
            $display("FAIL fill_wrap_push: count=%0d, required 16", ct_count);
        end
        ct_m_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ev = (k < 15) ? 8'(k + 2) : 8'h11;
            tests++;
            if ({ct_m_tvalid, ct_m_tdata} !== {1'b1, ev}) begin
                fails++;
                $display("FAIL fill_drain_%0d: valid/data=%b/%0h, required 1/%0h", k, ct_m_tvalid, ct_m_tdata, ev);
            end
            cycle();
            settle();
        end
        tests++;
        if ({ct_m_tvalid, ct_count} !== {1'b0, 5'd0}) begin
            fails++;
            $display("FAIL fill_drained: valid/count=%b/%0d, required 0/0", ct_m_tvalid, ct_count);
        end
        ct_m_tready = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ev;
        idle_inputs();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            ct_s_tvalid = 1'b1;
            ct_s_tdata  = 8'h20 + 8'(k);
            ct_s_tlast  = (k == 0);
            cycle();
        end
        ct_s_tvalid = 1'b0; ct_s_tlast = 1'b0;
        settle();
        tests++;
        if ({ct_count, ct_pkt_count} !== {5'd8, 5'd1}) begin
            fails++;
            $display("FAIL b2b_prefill: count/pkt=%0d/%0d, required 8/1", ct_count, ct_pkt_count);
        end
        ct_m_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ct_s_tvalid = 1'b1;
            ct_s_tdata  = 8'h28 + 8'(k);
            ct_s_tlast  = (k == 0);
            ev = 8'h20 + 8'(k);
            tests++;
            if ({ct_count, ct_pkt_count, ct_s_tready, ct_m_tvalid, ct_m_tdata} !==
                {5'd8, 5'd1, 1'b1, 1'b1, ev}) begin
                fails++;
                $display("FAIL b2b_cycle_%0d: count/pkt/ready/valid/data=%0d/%0d/%b/%b/%0h, required 8/1/1/1/%0h",
                         k, ct_count, ct_pkt_count, ct_s_tready, ct_m_tvalid, ct_m_tdata, ev);
            end
            cycle();
            settle();
        end
        ct_s_tvalid = 1'b0; ct_s_tlast = 1'b0;
        for (int j = 0; j < 8; j++) begin
            ev = 8'h25 + 8'(j);
            tests++;
            if ({ct_m_tvalid, ct_m_tlast, ct_m_tdata, ct_pkt_count} !==
                {1'b1, (j == 3), ev, (j <= 3) ? 5'd1 : 5'd0}) begin
                fails++;
                $display("FAIL b2b_drain_%0d: valid/last/data/pkt=%b/%b/%0h/%0d, required 1/%0d/%0h/%0d",
                         j, ct_m_tvalid, ct_m_tlast, ct_m_tdata, ct_pkt_count, (j == 3), ev, (j <= 3));
            end
            cycle();
            settle();
        end
        tests++;
        if ({ct_count, ct_pkt_count} !== {5'd0, 5'd0}) begin
            fails++;
            $display("FAIL b2b_end: count/pkt=%0d/%0d, required 0/0", ct_count, ct_pkt_count);
        end
        ct_m_tready = 1'b0;
        cycle();
    endtask

    task automatic test_packet_mode();
        logic [7:0] ev;
        idle_inputs();
        apply_reset();
        pk_m_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pk_s_tvalid = 1'b1;
            pk_s_tdata  = 8'h40 + 8'(k);
            pk_s_tlast  = (k == 3);
            settle();
            tests++;
            if (pk_m_tvalid !== 1'b0) begin
                fails++;
                $display("FAIL pkt_wait_%0d: m_tvalid=%b, required 0", k, pk_m_tvalid);
            end
            cycle();
        end
        pk_s_tvalid = 1'b0; pk_s_tlast = 1'b0;
        settle();
        tests++;
        if ({pk_m_tvalid, pk_pkt_count, pk_count} !== {1'b1, 5'd1, 5'd4}) begin
            fails++;
            $display("FAIL pkt_release: valid/pkt/count=%b/%0d/%0d, required 1/1/4", pk_m_tvalid, pk_pkt_count, pk_count);
        end
        for (int k = 0; k < 4; k++) begin
            ev = 8'h40 + 8'(k);
            tests++;
            if ({pk_m_tvalid, pk_m_tlast, pk_m_tdata, pk_pkt_count} !== {1'b1, (k == 3), ev, 5'd1}) begin
                fails++;
                $display("FAIL pkt_out_%0d: valid/last/data/pkt=%b/%b/%0h/%0d, required 1/%0d/%0h/1",
                         k, pk_m_tvalid, pk_m_tlast, pk_m_tdata, pk_pkt_count, (k == 3), ev);
            end
            cycle();
            settle();
        end
        tests++;
        if ({pk_m_tvalid, pk_pkt_count, pk_count} !== {1'b0, 5'd0, 5'd0}) begin
            fails++;
            $display("FAIL pkt_done: valid/pkt/count=%b/%0d/%0d, required 0/0/0", pk_m_tvalid, pk_pkt_count, pk_count);
        end
        pk_m_tready = 1'b0;
        cycle();
    endtask

    task automatic test_escape();
        int n_push, n_pop, mcount, first_rise;
        logic exp_valid, exp_ready, drove;
        logic [7:0] ev;
        idle_inputs();
        apply_reset();
        pk_m_tready = 1'b1;
        n_push = 0; n_pop = 0; mcount = 0; first_rise = -1;
        for (int cyc = 0; cyc < 200 && n_pop < 21; cyc++) begin
            drove = (n_push < 21);
            pk_s_tvalid = drove;
            pk_s_tdata  = 8'h60 + 8'(n_push);
            pk_s_tlast  = (n_push == 20);
            settle();
            exp_ready = (mcount != DEPTH);
            exp_valid = (mcount != 0) && (mcount == DEPTH || (n_push == 21 && n_pop < 21));
            tests++;
            if ({pk_s_tready, pk_m_tvalid} !== {exp_ready, exp_valid}) begin
                fails++;
                $display("FAIL escape_hs_cyc%0d: ready/valid=%b/%b, required %b/%b",
                         cyc, pk_s_tready, pk_m_tvalid, exp_ready, exp_valid);
            end
            if (exp_valid) begin
                ev = 8'h60 + 8'(n_pop);
                tests++;
                if (pk_m_tdata !== ev) begin
                    fails++;
                    $display("FAIL escape_data_%0d: data=%0h, required %0h", n_pop, pk_m_tdata, ev);
                end
                if (first_rise < 0) first_rise = cyc;
            end
            if (drove && exp_ready) begin
                n_push++;
                mcount++;
            end
            if (exp_valid) begin
                n_pop++;
                mcount--;
            end
            cycle();
        end
        pk_s_tvalid = 1'b0; pk_s_tlast = 1'b0;
        tests++;
        if (n_pop != 21) begin
            fails++;
            $display("FAIL escape_timeout: words drained=%0d, required 21", n_pop);
        end
        tests++;
        if (first_rise != 16) begin
            fails++;
            $display("FAIL escape_first_valid: first m_tvalid cycle=%0d, required 16", first_rise);
        end
        settle();
        tests++;
        if ({pk_count, pk_pkt_count, pk_m_tvalid} !== {5'd0, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL escape_end: count/pkt/valid=%0d/%0d/%b, required 0/0/0", pk_count, pk_pkt_count, pk_m_tvalid);
        end
        pk_m_tready = 1'b0;
        cycle();
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            ct_s_tvalid = 1'b1;
            ct_s_tdata  = 8'h50 + 8'(k);
            ct_s_tlast  = (k == 4);
            cycle();
        end
        ct_s_tvalid = 1'b0; ct_s_tlast = 1'b0;
        settle();
        tests++;
        if ({ct_count, ct_pkt_count, ct_m_tvalid, ct_m_tdata} !== {5'd5, 5'd1, 1'b1, 8'h50}) begin
            fails++;
            $display("FAIL midrst_pre: count/pkt/valid/data=%0d/%0d/%b/%0h, required 5/1/1/50",
                     ct_count, ct_pkt_count, ct_m_tvalid, ct_m_tdata);
        end
        reset = 1'b1;
        ct_m_tready = 1'b1;
        cycle();
        reset = 1'b0;
        settle();
        tests++;
        if ({ct_count, ct_pkt_count, ct_m_tvalid, ct_m_tlast, ct_m_tdata, ct_s_tready} !==
            {5'd0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL midrst_clear: count/pkt/valid/last/data/ready=%0d/%0d/%b/%b/%0h/%b, required 0/0/0/0/0/1",
                     ct_count, ct_pkt_count, ct_m_tvalid, ct_m_tlast, ct_m_tdata, ct_s_tready);
        end
        ct_s_tvalid = 1'b1;
        ct_s_tdata  = 8'h77;
        cycle();
        ct_s_tvalid = 1'b0;
        settle();
        tests++;
        if ({ct_m_tvalid, ct_m_tdata, ct_count} !== {1'b1, 8'h77, 5'd1}) begin
            fails++;
            $display("FAIL midrst_fresh: valid/data/count=%b/%0h/%0d, required 1/77/1", ct_m_tvalid, ct_m_tdata, ct_count);
        end
        cycle();
        settle();
        tests++;
        if ({ct_m_tvalid, ct_count} !== {1'b0, 5'd0}) begin
            fails++;
            $display("FAIL midrst_no_stale: valid/count=%b/%0d, required 0/0", ct_m_tvalid, ct_count);
        end
        ct_m_tready = 1'b0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_cut_through();
        test_fill_backpressure();
        test_back_to_back();
        test_packet_mode();
        test_escape();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
